// File: rtl/dct2d_sequencer.sv
// Control sequencer for a row/column 2D DCT built around a single 1D core and
// a transpose memory: loads a block, runs N row lines, then N column lines.
module dct2d_sequencer #(
  parameter int N     = 8,
  parameter int LOG2N = 3,
  parameter int AW    = 2*LOG2N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_core_done,
  output logic          o_core_start,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_rd,
  output logic          o_mem_wr,
  output logic          o_wr_sel_ext,
  output logic [N-1:0]  o_ld_in,
  output logic [N-1:0]  o_ld_out,
  output logic          o_pass,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RD, S_START, S_WAIT, S_WR, S_DONE
  } state_t;

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N-1);

  state_t               r_state, w_next;
  logic [LOG2N-1:0]     r_elem, r_line;
  logic                 r_pass;
  logic                 w_elem_last, w_line_last;
  logic [2*LOG2N-1:0]   w_lin;
  logic [AW-1:0]        w_addr_rw;
  logic [N-1:0]         w_onehot;

  assign w_elem_last = (r_elem == LAST);
  assign w_line_last = (r_line == LAST);
  assign w_lin       = {r_line, r_elem};
  // Column pass walks the same memory with line/elem swapped: the transpose.
  assign w_addr_rw   = r_pass ? AW'({r_elem, r_line}) : AW'(w_lin);
  assign w_onehot    = N'(1) << r_elem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_LOAD;
      S_LOAD:  if (w_line_last && w_elem_last) w_next = S_RD;
      S_RD:    if (w_elem_last) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT:  if (i_core_done) w_next = S_WR;
      S_WR:    if (w_elem_last) w_next = (w_line_last && r_pass) ? S_DONE : S_RD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (i_abort && r_state != S_IDLE) w_next = S_IDLE;
  end

  // Counters return to zero whenever the FSM heads for IDLE (abort, finish).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_elem <= '0;
      r_line <= '0;
      r_pass <= 1'b0;
    end else if (w_next == S_IDLE) begin
      r_elem <= '0;
      r_line <= '0;
      r_pass <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: {r_line, r_elem} <= w_lin + 1'b1;
        S_RD:   r_elem <= r_elem + 1'b1;
        S_WR: begin
          r_elem <= r_elem + 1'b1;
          if (w_elem_last) begin
            r_line <= r_line + 1'b1;
            if (w_line_last) r_pass <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_core_start = 1'b0;
    o_mem_addr   = '0;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    o_wr_sel_ext = 1'b0;
    o_ld_in      = '0;
    o_ld_out     = '0;
    o_done       = 1'b0;
    o_busy       = (r_state != S_IDLE);
    o_pass       = r_pass;
    case (r_state)
      S_LOAD: begin
        o_mem_wr     = 1'b1;
        o_wr_sel_ext = 1'b1;
        o_mem_addr   = AW'(w_lin);
      end
      S_RD: begin
        o_mem_rd   = 1'b1;
        o_ld_in    = w_onehot;
        o_mem_addr = w_addr_rw;
      end
      S_START: o_core_start = 1'b1;
      S_WR: begin
        o_mem_wr   = 1'b1;
        o_ld_out   = w_onehot;
        o_mem_addr = w_addr_rw;
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dct2d_sequencer.sv
// Directed bench for dct2d_sequencer: per-cycle vector table on an N=8
// instance plus hand sequences for abort, reset, delayed core and N=4 timing.
module tb_dct2d_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, core_done = 1'b0, sel = 1'b0;

  always #5 clk = ~clk;

  logic       cs8, rd8, wr8, se8, ps8, bs8, dn8;
  logic [5:0] a8;
  logic [7:0] li8, lo8;
  logic       cs4, rd4, wr4, se4, ps4, bs4, dn4;
  logic [3:0] a4, li4, lo4;

  dct2d_sequencer #(.N(8), .LOG2N(3), .AW(6)) u_dut8 (
    .clk(clk), .rst(rst), .i_start(start & ~sel), .i_abort(abort & ~sel),
    .i_core_done(core_done & ~sel), .o_core_start(cs8), .o_mem_addr(a8),
    .o_mem_rd(rd8), .o_mem_wr(wr8), .o_wr_sel_ext(se8), .o_ld_in(li8),
    .o_ld_out(lo8), .o_pass(ps8), .o_busy(bs8), .o_done(dn8));

  dct2d_sequencer #(.N(4), .LOG2N(2), .AW(4)) u_dut4 (
    .clk(clk), .rst(rst), .i_start(start & sel), .i_abort(abort & sel),
    .i_core_done(core_done & sel), .o_core_start(cs4), .o_mem_addr(a4),
    .o_mem_rd(rd4), .o_mem_wr(wr4), .o_wr_sel_ext(se4), .o_ld_in(li4),
    .o_ld_out(lo4), .o_pass(ps4), .o_busy(bs4), .o_done(dn4));

  logic m_cs, m_rd, m_busy, m_done;
  assign m_cs   = sel ? cs4 : cs8;
  assign m_rd   = sel ? rd4 : rd8;
  assign m_busy = sel ? bs4 : bs8;
  assign m_done = sel ? dn4 : dn8;

  logic [28:0] pk8;
  assign pk8 = {a8, rd8, wr8, se8, li8, lo8, cs8, dn8, bs8, ps8};

  typedef struct {
    int         cyc;
    logic [5:0] addr;
    logic       rd, wr, sel;
    logic [7:0] ldi, ldo;
    logic       cs, dn, bsy, ps;
  } vec_t;
  vec_t tbl[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input int c, input int a, input bit rd, input bit wr, input bit se,
                     input int li, input int lo, input bit cs, input bit dn,
                     input bit bs, input bit ps);
    vec_t v;
    v.cyc = c; v.addr = 6'(a); v.rd = rd; v.wr = wr; v.sel = se;
    v.ldi = 8'(li); v.ldo = 8'(lo); v.cs = cs; v.dn = dn; v.bsy = bs; v.ps = ps;
    tbl.push_back(v);
  endtask

  function automatic logic [28:0] pack(input vec_t v);
    return {v.addr, v.rd, v.wr, v.sel, v.ldi, v.ldo, v.cs, v.dn, v.bsy, v.ps};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the first LOAD cycle. The core model answers core_done on the
  // w-th WAIT cycle; spur adds core_done pulses in START and RD cycles.
  task automatic run(input bit use4, input int w, input bit spur, input bit restart,
                     input int abort_at, input int rst_at, input bit use_tbl,
                     output int done_cyc, output int cs_cnt, output int dn_cnt);
    int wcnt, last;
    sel = use4;
    done_cyc = -1; cs_cnt = 0; dn_cnt = 0; wcnt = 0; last = 3000;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int cyc = 0; cyc < last; cyc++) begin
      if (use_tbl)
        foreach (tbl[i])
          if (tbl[i].cyc == cyc) chk($sformatf("vec@%0d", cyc), 32'(pk8), 32'(pack(tbl[i])));
      if (m_cs) cs_cnt++;
      if (m_done) begin
        dn_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          last = cyc + 4;
        end
      end
      if (abort_at >= 0 && cyc == abort_at)
        chk("abort_state_wr", {23'd0, wr8, lo8}, {23'd0, 1'b1, 8'h04});
      if (abort_at >= 0 && cyc == abort_at + 1) begin
        chk("abort_busy", 32'(m_busy), 32'd0);
        chk("abort_outs", 32'(pk8), 32'd0);
        last = cyc + 3;
      end
      start = restart && cyc >= 100 && cyc <= 102;
      abort = (abort_at >= 0 && cyc == abort_at);
      if (m_cs) begin
        core_done = spur;
        wcnt = 1;
      end else if (wcnt > 0) begin
        core_done = (wcnt == w);
        wcnt = (wcnt == w) ? 0 : wcnt + 1;
      end else begin
        core_done = spur && m_rd;
      end
      if (rst_at >= 0 && cyc == rst_at) begin
        chk("rd_before_rst", 32'(rd8), 32'd1);
        rst = 1'b1;
        #2;
        chk("rst_async_outs", 32'(pk8), 32'd0);
        step;
        rst = 1'b0;
        break;
      end
      step;
    end
    abort = 1'b0; core_done = 1'b0; start = 1'b0;
  endtask

  int dc, cc, nc;

  initial begin
    add(  0,  0, 0,1,1, 'h00,'h00, 0,0,1,0);
    add( 37, 37, 0,1,1, 'h00,'h00, 0,0,1,0);
    add( 63, 63, 0,1,1, 'h00,'h00, 0,0,1,0);
    add( 64,  0, 1,0,0, 'h01,'h00, 0,0,1,0);
    add( 71,  7, 1,0,0, 'h80,'h00, 0,0,1,0);
    add( 72,  0, 0,0,0, 'h00,'h00, 1,0,1,0);
    add( 73,  0, 0,0,0, 'h00,'h00, 0,0,1,0);
    add( 74,  0, 0,1,0, 'h00,'h01, 0,0,1,0);
    add( 81,  7, 0,1,0, 'h00,'h80, 0,0,1,0);
    add( 82,  8, 1,0,0, 'h01,'h00, 0,0,1,0);
    add(118, 24, 1,0,0, 'h01,'h00, 0,0,1,0);
    add(130, 26, 0,1,0, 'h00,'h04, 0,0,1,0);
    add(207, 63, 0,1,0, 'h00,'h80, 0,0,1,0);
    add(208,  0, 1,0,0, 'h01,'h00, 0,0,1,1);
    add(209,  8, 1,0,0, 'h02,'h00, 0,0,1,1);
    add(226,  1, 1,0,0, 'h01,'h00, 0,0,1,1);
    add(229, 25, 1,0,0, 'h08,'h00, 0,0,1,1);
    add(233, 57, 1,0,0, 'h80,'h00, 0,0,1,1);
    add(234,  0, 0,0,0, 'h00,'h00, 1,0,1,1);
    add(236,  1, 0,1,0, 'h00,'h01, 0,0,1,1);
    add(241, 41, 0,1,0, 'h00,'h20, 0,0,1,1);
    add(243, 57, 0,1,0, 'h00,'h80, 0,0,1,1);
    add(351, 63, 0,1,0, 'h00,'h80, 0,0,1,1);
    add(352,  0, 0,0,0, 'h00,'h00, 0,1,1,1);
    add(353,  0, 0,0,0, 'h00,'h00, 0,0,0,0);

    step; step;
    chk("reset_outs8", 32'(pk8), 32'd0);
    chk("reset_busy4", 32'(bs4), 32'd0);
    rst = 1'b0;
    step; step;
    chk("idle_hold", 32'(pk8), 32'd0);

    // Full N=8 transform, W=1, start re-asserted during the row pass.
    run(1'b0, 1, 1'b1, 1'b1, -1, -1, 1'b1, dc, cc, nc);
    chk("done_cycle_w1", 32'(dc), 32'd352);
    chk("core_starts_w1", 32'(cc), 32'd16);
    chk("done_count_w1", 32'(nc), 32'd1);
    step; step;
    chk("no_queued_start", 32'(m_busy), 32'd0);

    // Delayed core (W=6) with spurious core_done in START and RD.
    run(1'b0, 6, 1'b1, 1'b0, -1, -1, 1'b0, dc, cc, nc);
    chk("done_cycle_w6", 32'(dc), 32'd432);
    chk("core_starts_w6", 32'(cc), 32'd16);

    // Abort in WR of row line 3, then a fresh start.
    run(1'b0, 1, 1'b0, 1'b0, 130, -1, 1'b0, dc, cc, nc);
    chk("abort_no_done", 32'(nc), 32'd0);
    run(1'b0, 1, 1'b0, 1'b0, -1, -1, 1'b0, dc, cc, nc);
    chk("after_abort_done", 32'(dc), 32'd352);

    // Reset mid-RD, then a fresh start runs a full transform.
    run(1'b0, 1, 1'b0, 1'b0, -1, 66, 1'b0, dc, cc, nc);
    chk("rst_no_done", 32'(nc), 32'd0);
    chk("rst_busy", 32'(bs8), 32'd0);
    run(1'b0, 1, 1'b0, 1'b0, -1, -1, 1'b0, dc, cc, nc);
    chk("after_rst_done", 32'(dc), 32'd352);
    chk("after_rst_starts", 32'(cc), 32'd16);

    // N=4 instance, W=2: 16 + 8*(9+2).
    run(1'b1, 2, 1'b0, 1'b0, -1, -1, 1'b0, dc, cc, nc);
    chk("n4_done_cycle", 32'(dc), 32'd104);
    chk("n4_core_starts", 32'(cc), 32'd8);
    chk("n4_done_count", 32'(nc), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dct2d_sequencer.md
DCT2D_SEQUENCER -- requirements
Module: dct2d_sequencer

Interface
REQ-001 Parameter N, default 8: transform size (points per line, lines per block); SHALL be a power of two in 4..32.
REQ-002 Parameter LOG2N, default 3: log2(N).
REQ-003 Parameter AW, default 2*LOG2N: transpose-memory address width.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 start  in  1  request a 2D transform; sampled only in IDLE.
REQ-007 abort  in  1  synchronous cancel; honoured in any non-IDLE state.
REQ-008 core_done  in  1  1D core finished current line; sampled only in WAIT.
REQ-009 core_start  out  1  one-cycle pulse launching the 1D core.
REQ-010 mem_addr  out  AW  transpose-memory address.
REQ-011 mem_rd  out  1  memory read strobe; read is combinational.
REQ-012 mem_wr  out  1  memory write strobe.
REQ-013 wr_sel_ext  out  1  1 = memory write data from external input port, 0 = from core output.
REQ-014 ld_in  out  N  one-hot load of core input register k.
REQ-015 ld_out  out  N  one-hot select of core output register k onto the write bus.
REQ-016 pass  out  1  0 = row pass, 1 = column pass.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse on completion.

Function
REQ-019 States: IDLE, LOAD, RD, START, WAIT, WR, DONE; encoding free.
REQ-020 Counters: elem (LOG2N bits), line (LOG2N bits), pass (1 bit); elem and line wrap modulo N.
REQ-021 IDLE: start=1 -> LOAD, with elem, line, pass cleared; start=0 -> stay.
REQ-022 LOAD: mem_wr=1, wr_sel_ext=1, mem_addr={line,elem}; lasts N*N cycles, incrementing {line,elem} as one counter; after the last cycle -> RD with line=elem=0.
REQ-023 RD: mem_rd=1, ld_in[elem]=1; lasts N cycles, elem 0..N-1; last cycle -> START.
REQ-024 Address mapping in RD/WR: pass=0 -> mem_addr = line*N + elem; pass=1 -> mem_addr = elem*N + line (transposed).
REQ-025 START: core_start=1 for exactly one cycle -> WAIT.
REQ-026 WAIT: holds until core_done=1, then -> WR with elem=0; core_done in the START cycle is ignored.
REQ-027 WR: mem_wr=1, wr_sel_ext=0, ld_out[elem]=1, same address mapping as RD; lasts N cycles.
REQ-028 End of WR: line<N-1 -> RD with line+1.
REQ-029 End of WR, line=N-1, pass=0 -> RD with pass=1, line=0.
REQ-030 End of WR, line=N-1, pass=1 -> DONE.
REQ-031 DONE: done=1 for one cycle -> IDLE; results remain in memory.
REQ-032 All strobes (mem_rd, mem_wr, core_start, ld_in, ld_out, done) SHALL be 0 outside their named states; ld_in and ld_out are zero or one-hot.
REQ-033 Timing: with WAIT occupancy W cycles per line, done asserts N*N + 2*N*(2N+1+W) cycles after the first LOAD cycle.
REQ-034 start while busy SHALL be ignored and not queued.
REQ-035 abort=1 in any non-IDLE state -> IDLE next cycle, with all strobes 0 in that cycle, counters cleared and no done; abort outranks core_done and state completion in the same cycle.
REQ-036 core_done outside WAIT SHALL be ignored.

Reset
REQ-037 rst=1 SHALL immediately force IDLE, clear elem, line and pass, and drive every output to 0 (mem_addr=0), including mid-transfer.
REQ-038 After rst deasserts, the first start SHALL run a complete transform from LOAD.

Verification
REQ-039 N=8, start pulse, core_done on the first WAIT cycle -> LOAD writes addresses 0..63 in order, then done at cycle 352 after the first LOAD cycle, lasting one cycle.
REQ-040 N=8, column pass line 1 -> RD addresses 1,9,17,...,57 with ld_in 0x01..0x80; WR addresses identical with ld_out 0x01..0x80.
REQ-041 core_done delayed 5 cycles in WAIT, with a spurious core_done in START and in RD -> only the WAIT pulse advances the FSM; core_start pulses exactly 16 times per transform.
REQ-042 start re-asserted during the row pass -> no restart; exactly one done is produced.
REQ-043 abort in WR of row line 3 -> busy=0 next cycle, no done; a fresh start then completes normally.
REQ-044 rst asserted mid-RD between clock edges -> outputs are 0 before the next edge; N=4 instance gives done at 16 + 8*(9+W) cycles.
